// File: rtl/intra16_mode_ctrl.sv
// Sequencer and mode decision for the 16x16 luma intra predictor: streams 16 rows,
// accumulates one SAD per mode (V/H/DC) and registers the cheapest enabled mode.
module intra16_mode_ctrl #(
  parameter int unsigned PW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             top_avail,
  input  logic             left_avail,
  output logic             pred_enable,
  output logic [3:0]       row_idx,
  output logic             row_req,
  input  logic [16*PW-1:0] src_row,
  input  logic [16*PW-1:0] vpred_row,
  input  logic [16*PW-1:0] hpred_row,
  input  logic [16*PW-1:0] dcpred_row,
  output logic             busy,
  output logic             done,
  output logic [1:0]       best_mode,
  output logic [15:0]      best_sad
);

  typedef enum logic [2:0] {StIdle, StPred, StScan, StDrain, StDecide} state_e;

  state_e      state_q, state_d;
  logic [3:0]  row_idx_q, row_idx_d;
  logic        pred_enable_q, pred_enable_d;
  logic        row_req_q, row_req_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        rd_vld_q;
  logic        top_q, left_q;
  logic [15:0] v_acc_q, h_acc_q, dc_acc_q;
  logic [1:0]  best_mode_q, best_mode_d;
  logic [15:0] best_sad_q, best_sad_d;
  logic [11:0] v_sad, h_sad, dc_sad;
  logic        accept;

  function automatic logic [11:0] row_sad(input logic [16*PW-1:0] a, input logic [16*PW-1:0] b);
    logic [11:0] s;
    logic [PW:0] d;
    s = '0;
    for (int c = 0; c < 16; c++) begin
      d = {1'b0, a[PW*c +: PW]} - {1'b0, b[PW*c +: PW]};
      if (d[PW]) d = -d;
      s = s + 12'(d);
    end
    return s;
  endfunction

  assign v_sad  = row_sad(src_row, vpred_row);
  assign h_sad  = row_sad(src_row, hpred_row);
  assign dc_sad = row_sad(src_row, dcpred_row);
  assign accept = (state_q == StIdle) && start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      row_idx_q     <= '0;
      pred_enable_q <= 1'b0;
      row_req_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rd_vld_q      <= 1'b0;
      top_q         <= 1'b0;
      left_q        <= 1'b0;
      v_acc_q       <= '0;
      h_acc_q       <= '0;
      dc_acc_q      <= '0;
      best_mode_q   <= '0;
      best_sad_q    <= '0;
    end else begin
      state_q       <= state_d;
      row_idx_q     <= row_idx_d;
      pred_enable_q <= pred_enable_d;
      row_req_q     <= row_req_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      rd_vld_q      <= row_req_q;
      best_mode_q   <= best_mode_d;
      best_sad_q    <= best_sad_d;
      if (accept) begin
        top_q    <= top_avail;
        left_q   <= left_avail;
        v_acc_q  <= '0;
        h_acc_q  <= '0;
        dc_acc_q <= '0;
      end else if (rd_vld_q) begin
        // Row data lags the request by one cycle.
        v_acc_q  <= v_acc_q + 16'(v_sad);
        h_acc_q  <= h_acc_q + 16'(h_sad);
        dc_acc_q <= dc_acc_q + 16'(dc_sad);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StPred;
      StPred:   state_d = StScan;
      StScan:   if (row_idx_q == 4'd15) state_d = StDrain;
      StDrain:  state_d = StDecide;
      StDecide: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are precomputed from the next state so every port comes straight from a flop.
  always_comb begin
    pred_enable_d = (state_d == StPred);
    row_req_d     = (state_d == StScan);
    busy_d        = (state_d != StIdle);
    done_d        = (state_q == StDecide);
    row_idx_d     = (state_q == StScan) ? row_idx_q + 4'd1 : row_idx_q;
    best_mode_d   = best_mode_q;
    best_sad_d    = best_sad_q;
    if (state_q == StDecide) begin
      // Evaluated DC -> H -> V with <= so ties go to the lower mode number.
      best_mode_d = 2'd2;
      best_sad_d  = dc_acc_q;
      if (left_q && (h_acc_q <= best_sad_d)) begin
        best_mode_d = 2'd1;
        best_sad_d  = h_acc_q;
      end
      if (top_q && (v_acc_q <= best_sad_d)) begin
        best_mode_d = 2'd0;
        best_sad_d  = v_acc_q;
      end
    end
  end

  assign pred_enable = pred_enable_q;
  assign row_idx     = row_idx_q;
  assign row_req     = row_req_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign best_mode   = best_mode_q;
  assign best_sad    = best_sad_q;

endmodule
